// File: rtl/pop_qq_sequencer_pkg.sv
// Shared encodings for the POP/PUSH qq datapath: register byte selects,
// register-pair field values and the sequencer state type.
package pop_qq_sequencer_pkg;

   localparam logic [2:0] REG_B = 3'd0;
   localparam logic [2:0] REG_C = 3'd1;
   localparam logic [2:0] REG_D = 3'd2;
   localparam logic [2:0] REG_E = 3'd3;
   localparam logic [2:0] REG_H = 3'd4;
   localparam logic [2:0] REG_L = 3'd5;
   localparam logic [2:0] REG_F = 3'd6;
   localparam logic [2:0] REG_A = 3'd7;

   localparam logic [1:0] QQ_BC = 2'b00;
   localparam logic [1:0] QQ_DE = 2'b01;
   localparam logic [1:0] QQ_HL = 2'b10;
   localparam logic [1:0] QQ_AF = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_LO = 2'd1,
      RD_HI = 2'd2,
      FIN   = 2'd3
   } pop_state_t;

endpackage

// File: rtl/pop_qq_sequencer_if.sv
// Decoder / memory / register-file bundle of the POP qq sequencer.
// slave is the sequencer side, master is the surrounding core.
interface pop_qq_sequencer_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic              start;
   logic [1:0]        qq;
   logic [ADDR_W-1:0] sp_in;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic              wr_en;
   logic [2:0]        wr_sel;
   logic [DATA_W-1:0] wr_data;
   logic              sp_we;
   logic [ADDR_W-1:0] sp_out;
   logic              busy;
   logic              op_done;

   modport master (
      output start, qq, sp_in, mem_rdata, mem_ready,
      input  mem_rd, mem_addr, wr_en, wr_sel, wr_data, sp_we, sp_out, busy, op_done
   );

   modport slave (
      input  start, qq, sp_in, mem_rdata, mem_ready,
      output mem_rd, mem_addr, wr_en, wr_sel, wr_data, sp_we, sp_out, busy, op_done
   );
endinterface

// File: rtl/pop_qq_regsel.sv
// Maps a qq register-pair field and byte phase to a register-file byte select.
// Purely combinational; shared with the PUSH path.
module pop_qq_regsel
   import pop_qq_sequencer_pkg::*;
(
   input  logic [1:0] qq,
   input  logic       hi,
   output logic [2:0] sel
);

   always_comb begin
      sel = REG_B;
      unique case (qq)
         QQ_BC: sel = hi ? REG_B : REG_C;
         QQ_DE: sel = hi ? REG_D : REG_E;
         QQ_HL: sel = hi ? REG_H : REG_L;
         QQ_AF: sel = hi ? REG_A : REG_F;
         default: sel = REG_B;
      endcase
   end

endmodule

// File: rtl/pop_qq_sequencer.sv
// POP qq executor: two stack reads (low at SP, high at SP+1), register writes, SP+2.
// Latency start->op_done is 3 cycles plus memory wait states; start is ignored while busy.
module pop_qq_sequencer
   import pop_qq_sequencer_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input logic               CLK,
   input logic               notReset,
   pop_qq_sequencer_if.slave bus
);

   localparam logic [ADDR_W-1:0] SP_ONE = ADDR_W'(1);

   pop_state_t        state;
   logic [ADDR_W-1:0] sp_r;
   logic [ADDR_W-1:0] sp_inc;
   logic [1:0]        qq_r;
   logic [2:0]        sel;
   logic              mem_rd;
   logic              wr_en;
   logic [2:0]        wr_sel;
   logic [DATA_W-1:0] wr_data;
   logic              sp_we;
   logic [ADDR_W-1:0] sp_out;
   logic              busy;
   logic              op_done;

   // SP wraps naturally modulo 2^ADDR_W
   assign sp_inc = sp_r + SP_ONE;

   pop_qq_regsel u_regsel (
      .qq  (qq_r),
      .hi  (state == RD_HI),
      .sel (sel)
   );

   always_ff @(posedge CLK or negedge notReset) begin
      if (!notReset) begin
         state   <= IDLE;
         sp_r    <= '0;
         qq_r    <= '0;
         mem_rd  <= 1'b0;
         wr_en   <= 1'b0;
         wr_sel  <= '0;
         wr_data <= '0;
         sp_we   <= 1'b0;
         sp_out  <= '0;
         busy    <= 1'b0;
         op_done <= 1'b0;
      end else begin
         wr_en   <= 1'b0;
         sp_we   <= 1'b0;
         op_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  sp_r   <= bus.sp_in;
                  qq_r   <= bus.qq;
                  mem_rd <= 1'b1;
                  busy   <= 1'b1;
                  state  <= RD_LO;
               end
            end
            RD_LO, RD_HI: begin
               if (bus.mem_ready) begin
                  wr_en   <= 1'b1;
                  wr_sel  <= sel;
                  wr_data <= bus.mem_rdata;
                  sp_r    <= sp_inc;
                  sp_we   <= 1'b1;
                  sp_out  <= sp_inc;
                  if (state == RD_HI) begin
                     mem_rd  <= 1'b0;
                     op_done <= 1'b1;
                     state   <= FIN;
                  end else begin
                     state <= RD_HI;
                  end
               end
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read address is the live stack pointer; it only moves when a read completes
   assign bus.mem_rd   = mem_rd;
   assign bus.mem_addr = sp_r;
   assign bus.wr_en    = wr_en;
   assign bus.wr_sel   = wr_sel;
   assign bus.wr_data  = wr_data;
   assign bus.sp_we    = sp_we;
   assign bus.sp_out   = sp_out;
   assign bus.busy     = busy;
   assign bus.op_done  = op_done;

endmodule

// File: tb/tb_pop_qq_sequencer.sv
// Directed bench for pop_qq_sequencer with a wait-state capable memory responder.
module tb_pop_qq_sequencer;
   import pop_qq_sequencer_pkg::*;

   logic CLK = 1'b0;
   logic notReset = 1'b0;
   always #5 CLK = ~CLK;

   pop_qq_sequencer_if bus ();

   pop_qq_sequencer dut (
      .CLK      (CLK),
      .notReset (notReset),
      .bus      (bus)
   );

   logic [7:0]  mem [0:65535];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc;
   int          nwait;
   int          wcnt;
   bit          repulse;
   int          wr_n, sp_n, ad_n, op_n, op_cyc;
   logic [2:0]  wr_sel_l [8];
   logic [7:0]  wr_dat_l [8];
   int          wr_cyc_l [8];
   logic [15:0] sp_l [8];
   logic [15:0] ad_l [16];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      wr_n = 0; sp_n = 0; ad_n = 0; op_n = 0; op_cyc = 0; cyc = 0;
   endtask

   // One clock: sample outputs 1 time unit after the edge, then set up inputs
   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
      if (bus.wr_en) begin
         if (wr_n < 8) begin
            wr_sel_l[wr_n] = bus.wr_sel;
            wr_dat_l[wr_n] = bus.wr_data;
            wr_cyc_l[wr_n] = cyc;
         end
         wr_n++;
      end
      if (bus.sp_we) begin
         if (sp_n < 8) sp_l[sp_n] = bus.sp_out;
         sp_n++;
      end
      if (bus.mem_rd) begin
         if (ad_n < 16) ad_l[ad_n] = bus.mem_addr;
         ad_n++;
      end
      if (bus.op_done) begin
         op_n++;
         op_cyc = cyc;
      end
      if (bus.mem_rd && wcnt < nwait) begin
         bus.mem_ready = 1'b0;
         wcnt++;
      end else begin
         bus.mem_ready = 1'b1;
         wcnt = 0;
      end
      bus.mem_rdata = mem[bus.mem_addr];
      bus.start = repulse && (cyc == 1 || bus.op_done);
   endtask

   task automatic run_op(input logic [1:0] q, input logic [15:0] sp, input int w, input bit rep);
      clear_logs();
      nwait = w;
      wcnt = 0;
      repulse = rep;
      bus.qq = q;
      bus.sp_in = sp;
      bus.start = 1'b1;
      tick();
      for (int i = 0; i < 30 && op_n == 0; i++) tick();
      for (int i = 0; i < 3; i++) tick();
      repulse = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      bus.start = 1'b0; bus.qq = 2'b00; bus.sp_in = 16'h0000;
      bus.mem_rdata = 8'h00; bus.mem_ready = 1'b1;
      repulse = 1'b0; nwait = 0; wcnt = 0;
      clear_logs();

      #12;
      chk("rst_mem_rd",  32'(bus.mem_rd),   0);
      chk("rst_addr",    32'(bus.mem_addr), 0);
      chk("rst_wr_en",   32'(bus.wr_en),    0);
      chk("rst_wr_sel",  32'(bus.wr_sel),   0);
      chk("rst_sp_out",  32'(bus.sp_out),   0);
      chk("rst_busy",    32'(bus.busy),     0);
      chk("rst_op_done", 32'(bus.op_done),  0);
      notReset = 1'b1;
      tick(); tick();

      // BC from 1000, zero wait
      mem[16'h1000] = 8'h34; mem[16'h1001] = 8'h12;
      run_op(QQ_BC, 16'h1000, 0, 1'b0);
      chk("t1_wr_n",   32'(wr_n), 2);
      chk("t1_sel0",   32'(wr_sel_l[0]), 32'(REG_C));
      chk("t1_dat0",   32'(wr_dat_l[0]), 32'h34);
      chk("t1_cyc0",   32'(wr_cyc_l[0]), 2);
      chk("t1_sel1",   32'(wr_sel_l[1]), 32'(REG_B));
      chk("t1_dat1",   32'(wr_dat_l[1]), 32'h12);
      chk("t1_cyc1",   32'(wr_cyc_l[1]), 3);
      chk("t1_sp0",    32'(sp_l[0]), 32'h1001);
      chk("t1_sp1",    32'(sp_l[1]), 32'h1002);
      chk("t1_ad0",    32'(ad_l[0]), 32'h1000);
      chk("t1_ad1",    32'(ad_l[1]), 32'h1001);
      chk("t1_ad_n",   32'(ad_n), 2);
      chk("t1_op_cyc", 32'(op_cyc), 3);
      chk("t1_op_n",   32'(op_n), 1);
      chk("t1_idle",   32'(bus.busy), 0);

      // AF across the top of memory
      mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hA5;
      run_op(QQ_AF, 16'hFFFF, 0, 1'b0);
      chk("t2_sel0", 32'(wr_sel_l[0]), 32'(REG_F));
      chk("t2_dat0", 32'(wr_dat_l[0]), 32'h5A);
      chk("t2_sel1", 32'(wr_sel_l[1]), 32'(REG_A));
      chk("t2_dat1", 32'(wr_dat_l[1]), 32'hA5);
      chk("t2_ad0",  32'(ad_l[0]), 32'hFFFF);
      chk("t2_ad1",  32'(ad_l[1]), 32'h0000);
      chk("t2_sp0",  32'(sp_l[0]), 32'h0000);
      chk("t2_sp1",  32'(sp_l[1]), 32'h0001);

      // HL with two wait states per read
      mem[16'h2000] = 8'h77; mem[16'h2001] = 8'h88;
      run_op(QQ_HL, 16'h2000, 2, 1'b0);
      chk("t3_ad_n",   32'(ad_n), 6);
      chk("t3_ad0",    32'(ad_l[0]), 32'h2000);
      chk("t3_ad2",    32'(ad_l[2]), 32'h2000);
      chk("t3_ad3",    32'(ad_l[3]), 32'h2001);
      chk("t3_ad5",    32'(ad_l[5]), 32'h2001);
      chk("t3_sel0",   32'(wr_sel_l[0]), 32'(REG_L));
      chk("t3_cyc0",   32'(wr_cyc_l[0]), 4);
      chk("t3_sel1",   32'(wr_sel_l[1]), 32'(REG_H));
      chk("t3_dat1",   32'(wr_dat_l[1]), 32'h88);
      chk("t3_op_cyc", 32'(op_cyc), 7);

      // start re-pulsed in RD_LO and FIN must not spawn a second operation
      mem[16'h3000] = 8'h11; mem[16'h3001] = 8'h22;
      run_op(QQ_DE, 16'h3000, 0, 1'b1);
      chk("t4_wr_n",   32'(wr_n), 2);
      chk("t4_sp_n",   32'(sp_n), 2);
      chk("t4_op_n",   32'(op_n), 1);
      chk("t4_busy",   32'(bus.busy), 0);
      chk("t4_dat1",   32'(wr_dat_l[1]), 32'h22);

      // Reset asserted in the middle of a waited high-byte read
      mem[16'h4000] = 8'h99; mem[16'h4001] = 8'h66;
      clear_logs();
      nwait = 3; wcnt = 0;
      bus.qq = QQ_HL; bus.sp_in = 16'h4000; bus.start = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("t5_pre_wr_n", 32'(wr_n), 1);
      chk("t5_pre_busy", 32'(bus.busy), 1);
      chk("t5_pre_addr", 32'(bus.mem_addr), 32'h4001);
      notReset = 1'b0;
      #1;
      chk("t5_rst_mem_rd",  32'(bus.mem_rd),   0);
      chk("t5_rst_addr",    32'(bus.mem_addr), 0);
      chk("t5_rst_wr_en",   32'(bus.wr_en),    0);
      chk("t5_rst_wr_data", 32'(bus.wr_data),  0);
      chk("t5_rst_sp_we",   32'(bus.sp_we),    0);
      chk("t5_rst_sp_out",  32'(bus.sp_out),   0);
      chk("t5_rst_busy",    32'(bus.busy),     0);
      @(negedge CLK);
      notReset = 1'b1;
      clear_logs();
      nwait = 0; wcnt = 0;
      for (int i = 0; i < 5; i++) tick();
      chk("t5_post_wr_n", 32'(wr_n), 0);
      chk("t5_post_sp_n", 32'(sp_n), 0);
      chk("t5_post_op_n", 32'(op_n), 0);
      chk("t5_post_busy", 32'(bus.busy), 0);

      mem[16'h0100] = 8'hEE; mem[16'h0101] = 8'hDD;
      run_op(QQ_DE, 16'h0100, 0, 1'b0);
      chk("t6_wr_n",   32'(wr_n), 2);
      chk("t6_sel0",   32'(wr_sel_l[0]), 32'(REG_E));
      chk("t6_dat0",   32'(wr_dat_l[0]), 32'hEE);
      chk("t6_sel1",   32'(wr_sel_l[1]), 32'(REG_D));
      chk("t6_dat1",   32'(wr_dat_l[1]), 32'hDD);
      chk("t6_sp1",    32'(sp_l[1]), 32'h0102);
      chk("t6_op_cyc", 32'(op_cyc), 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
